hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage RISC-V core.
- Sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register, and drives their hold, bubble and flush controls.
- Detects load-use hazards and taken branches, and sequences multi-cycle data-memory accesses through a wait/timeout FSM.
- Keeps saturating counters of stall and flush events for debug.

---
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / memory-wait hazard controller
// for the 5-stage core, with saturating stall and flush counters.
module hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_wb,
  input  logic             ex_wb_sel,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] W_TO = WW'(MEM_TIMEOUT);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WW-1:0]    r_wait;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_loaduse;
  logic w_memhold;
  logic w_run;
  logic w_hold;
  logic w_flush;
  logic w_lu;
  logic w_on;

  assign w_loaduse = ex_reg_wb & ex_wb_sel & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) |
                      (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_memhold = mem_req & ~mem_ready;

  // Hazard decode; the release cycle of MEM_WAIT decodes like RUN.
  always_comb begin
    w_run   = (r_state == RUN) |
              ((r_state == MEM_WAIT) & mem_ready);
    w_hold  = (r_state == ERROR) |
              ((r_state == MEM_WAIT) & ~mem_ready) |
              ((r_state == RUN) & w_memhold);
    w_flush = w_run & ~w_hold & branch_taken;
    w_lu    = w_run & ~w_hold & ~branch_taken & w_loaduse;
  end

  // Outputs forced low while reset is held, independent of inputs.
  assign w_on         = ~reset;
  assign stall_pc     = w_on & (w_hold | w_lu);
  assign stall_if_id  = w_on & (w_hold | w_lu);
  assign stall_id_ex  = w_on & w_hold;
  assign stall_ex_mem = w_on & w_hold;
  assign bubble_id_ex = w_on & (w_flush | w_lu);
  assign flush_if_id  = w_on & w_flush;
  assign mem_err      = r_mem_err;
  assign stall_count  = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

  // Next-state selection for the memory wait / timeout FSM.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:
        if (w_memhold) w_next = MEM_WAIT;
      MEM_WAIT:
        if (mem_ready) w_next = RUN;
        else if (r_wait == W_TO) w_next = ERROR;
      ERROR:
        w_next = ERROR;
      default:
        w_next = RUN;
    endcase
  end

  // State, wait counter and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == RUN && w_memhold)
        r_wait <= WW'(1);
      else if (r_state == MEM_WAIT && mem_ready)
        r_wait <= '0;
      else if (r_state == MEM_WAIT && r_wait != W_TO)
        r_wait <= r_wait + WW'(1);
      if (w_next == ERROR)
        r_mem_err <= 1'b1;
    end
  end

  // Saturating debug counters of stall cycles and branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_pc && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_if_id && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand sequences
// for memory wait, timeout, saturation and async reset.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_reg_wb, ex_wb_sel;
  logic       branch_taken, mem_req, mem_ready;
  logic       stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic       bubble_id_ex, flush_if_id, mem_err;
  logic [3:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_wb(ex_reg_wb), .ex_wb_sel(ex_wb_sel),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .mem_err(mem_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // exp = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble, flush}
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wb, sel, br, mreq, mrdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[12];

  function automatic logic [5:0] outs();
    return {stall_pc, stall_if_id, stall_id_ex,
            stall_ex_mem, bubble_id_ex, flush_if_id};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    ex_reg_wb = 0; ex_wb_sel = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int sc, fc;

  initial begin
    reset = 1'b1;
    idle();
    vt[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
    vt[1]  = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0, 0, 6'b110010};
    vt[2]  = '{5'd0, 5'd0, 5'd0, 1, 0, 1, 1, 0, 0, 0, 6'b000000};
    vt[3]  = '{5'd1, 5'd7, 5'd7, 1, 1, 1, 1, 0, 0, 0, 6'b110010};
    vt[4]  = '{5'd1, 5'd7, 5'd7, 1, 0, 1, 1, 0, 0, 0, 6'b000000};
    vt[5]  = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 0, 6'b000000};
    vt[6]  = '{5'd5, 5'd0, 5'd5, 1, 0, 0, 1, 0, 0, 0, 6'b000000};
    vt[7]  = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, 0, 0, 6'b000011};
    vt[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 6'b000011};
    vt[9]  = '{5'd9, 5'd0, 5'd9, 1, 0, 1, 1, 0, 1, 1, 6'b110010};
    vt[10] = '{5'd4, 5'd3, 5'd5, 1, 1, 1, 1, 0, 0, 0, 6'b000000};
    vt[11] = '{5'd31, 5'd0, 5'd31, 1, 0, 1, 1, 0, 0, 0, 6'b110010};

    #1;
    chk("rst_outs", 32'(outs()), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_scnt", 32'(stall_count), 0);
    chk("rst_fcnt", 32'(flush_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Single-cycle RUN vectors with a running counter model.
    sc = 0; fc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_rs1 = vt[i].rs1; id_rs2 = vt[i].rs2; ex_rd = vt[i].rd;
      id_use_rs1 = vt[i].u1; id_use_rs2 = vt[i].u2;
      ex_reg_wb = vt[i].wb; ex_wb_sel = vt[i].sel;
      branch_taken = vt[i].br;
      mem_req = vt[i].mreq; mem_ready = vt[i].mrdy;
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp));
      sc += int'(vt[i].exp[5]);
      fc += int'(vt[i].exp[0]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_scnt", i), 32'(stall_count), 32'(sc));
      chk($sformatf("vec%0d_fcnt", i), 32'(flush_count), 32'(fc));
    end

    // Memory wait of 3 cycles, then ready.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait%0d_outs", i), 32'(outs()), 32'b111100);
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    chk("wait_rel_outs", 32'(outs()), 0);
    @(negedge clk);
    chk("wait_scnt", 32'(stall_count), 3);
    mem_req = 0; mem_ready = 0;
    #1;
    chk("wait_run_outs", 32'(outs()), 0);
    chk("wait_err", 32'(mem_err), 0);

    // Memhold and branch together; branch flushes on release.
    do_reset();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    #1;
    chk("sim_hold_outs", 32'(outs()), 32'b111100);
    @(negedge clk);
    chk("sim_fcnt0", 32'(flush_count), 0);
    #1;
    chk("sim_wait_outs", 32'(outs()), 32'b111100);
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("sim_rel_outs", 32'(outs()), 32'b000011);
    @(negedge clk);
    chk("sim_fcnt1", 32'(flush_count), 1);
    chk("sim_scnt", 32'(stall_count), 2);

    // Timeout to ERROR, then saturation of stall_count.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("to_err_e%0d", e), 32'(mem_err),
          (e == 5) ? 32'd1 : 32'd0);
    end
    chk("to_scnt5", 32'(stall_count), 5);
    @(negedge clk);
    mem_ready = 1;
    #1;
    chk("err_outs", 32'(outs()), 32'b111100);
    for (int e = 6; e <= 20; e++) @(posedge clk);
    #1;
    chk("sat_scnt", 32'(stall_count), 15);
    chk("sat_err", 32'(mem_err), 1);
    chk("sat_outs", 32'(outs()), 32'b111100);

    // Async reset in the middle of a memory wait.
    do_reset();
    mem_req = 1; mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_pre_outs", 32'(outs()), 32'b111100);
    reset = 1'b1;
    #1;
    chk("ar_outs", 32'(outs()), 0);
    chk("ar_scnt", 32'(stall_count), 0);
    chk("ar_fcnt", 32'(flush_count), 0);
    chk("ar_err", 32'(mem_err), 0);
    @(negedge clk);
    mem_req = 0;
    reset = 1'b0;
    #1;
    chk("ar_run_outs", 32'(outs()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  // Structural invariant checked on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (stall_id_ex && bubble_id_ex) begin
        errors++;
        $display("FAIL excl: stall_id_ex=1 bubble_id_ex=1 required not both");
      end
    end
  end

endmodule
